// File: rtl/mont_mult_arbiter.sv
// mont_mult_arbiter
//   Shares one Montgomery multiplier between N requesters. Start pulses are
//   latched as pending jobs and granted round-robin. For each job the arbiter
//   releases the multiplier reset, pulses its start, then waits for done.
//   The result is captured and returned to the granted requester together
//   with a one-cycle done pulse. A watchdog aborts the job if the multiplier
//   hangs; the requester then sees req_err=1 and a zero result.
//
// Ports
//   clk, resetn              clock, synchronous active-low reset
//   req_start[N]             per-requester start pulse
//   req_a/b/m[N*W]           operands; requester i occupies bits [i*W +: W]
//   req_busy[N]              job pending or in service
//   req_done[N]              one-hot completion pulse
//   req_err                  qualifies req_done: job aborted by watchdog
//   req_result[W]            shared result register, valid with req_done
//   mm_resetn, mm_start      multiplier local reset (active-low) and start
//   mm_a/b/m[W]              operands of the granted requester
//   mm_result[W], mm_done    multiplier result and completion pulse
module mont_mult_arbiter #(
    parameter int W       = 1024,
    parameter int N       = 2,
    parameter int TIMEOUT = 8192
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [N-1:0]   req_start,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N*W-1:0] req_m,
    output logic [N-1:0]   req_busy,
    output logic [N-1:0]   req_done,
    output logic           req_err,
    output logic [W-1:0]   req_result,
    output logic           mm_resetn,
    output logic           mm_start,
    output logic [W-1:0]   mm_a,
    output logic [W-1:0]   mm_b,
    output logic [W-1:0]   mm_m,
    input  logic [W-1:0]   mm_result,
    input  logic           mm_done
);

    localparam int          GW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [W-1:0]  result_q, result_d;
    logic          err_q, err_d;

    logic [N-1:0]  grant_oh;
    logic [GW-1:0] rr_idx;
    int            rr_best;

    assign grant_oh = {{(N-1){1'b0}}, 1'b1} << grant_q;

    // Round-robin pick: the pending requester with the smallest distance
    // from last_grant+1 (mod N) wins.
    always_comb begin
        rr_idx  = '0;
        rr_best = N;
        for (int k = 0; k < N; k++) begin
            if (pending_q[k] && (((k + N - 1 - int'(last_grant_q)) % N) < rr_best)) begin
                rr_best = (k + N - 1 - int'(last_grant_q)) % N;
                rr_idx  = GW'(k);
            end
        end
    end

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            grant_q      <= '0;
            last_grant_q <= GW'(N - 1);
            cnt_q        <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|pending_q) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (mm_done || (cnt_q == CNT_LAST)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        pending_d    = pending_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE:  if (|pending_q) grant_d = rr_idx;
            S_ISSUE: cnt_d = '0;
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A done arriving on the timeout cycle still counts as success.
                if (mm_done) begin
                    result_d = mm_result;
                    err_d    = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
            end
            S_DONE: begin
                pending_d    = pending_q & ~grant_oh;
                last_grant_d = grant_q;
            end
            default: ;
        endcase
        // Applied after the clear so a start in the DONE cycle opens a new job.
        pending_d = pending_d | req_start;
    end

    // Outputs decoded from registered state
    always_comb begin
        mm_resetn = (state_q == S_ISSUE) || (state_q == S_WAIT);
        mm_start  = (state_q == S_ISSUE);
        req_done  = (state_q == S_DONE) ? grant_oh : '0;
        req_err   = (state_q == S_DONE) && err_q;
    end

    // Operand mux; grant only changes in IDLE so the slice is stable in service.
    always_comb begin
        mm_a = req_a[W-1:0];
        mm_b = req_b[W-1:0];
        mm_m = req_m[W-1:0];
        for (int k = 0; k < N; k++) begin
            if (grant_q == GW'(k)) begin
                mm_a = req_a[k*W +: W];
                mm_b = req_b[k*W +: W];
                mm_m = req_m[k*W +: W];
            end
        end
    end

    assign req_busy   = pending_q;
    assign req_result = result_q;

endmodule

// File: tb/tb_mont_mult_arbiter.sv
module tb_mont_mult_arbiter;
    localparam int W       = 16;
    localparam int N       = 2;
    localparam int TIMEOUT = 20;
    localparam int LAT     = 10;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [N-1:0]   req_start = '0;
    logic [N*W-1:0] req_a = '0, req_b = '0, req_m = '0;
    logic [N-1:0]   req_busy, req_done;
    logic           req_err;
    logic [W-1:0]   req_result;
    logic           mm_resetn, mm_start;
    logic [W-1:0]   mm_a, mm_b, mm_m;
    logic [W-1:0]   mm_result = '0;
    logic           mm_done = 1'b0;

    always #5 clk = ~clk;

    mont_mult_arbiter #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .req_start(req_start),
        .req_a(req_a), .req_b(req_b), .req_m(req_m),
        .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
        .req_result(req_result), .mm_resetn(mm_resetn), .mm_start(mm_start),
        .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    int checks = 0, errors = 0, cyc = 0;

    // requester operand registers
    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];
    logic [W-1:0] op_m [N];

    // transaction-level reference: pending set, last winner, and the
    // schedule (issue/done cycle) of the job currently in service
    logic [N-1:0] m_pend = '0;
    int           m_last = N - 1;
    int           m_grant = 0;
    int           issue_at = -1, done_at = -1, free_at = 0;
    logic [W-1:0] exp_res = '0, hold_res = '0;
    logic         exp_err = 1'b0;

    // mock multiplier: returns a^b LAT cycles after start, or never if hang
    bit           hang = 1'b0;
    int           mock_at = -1;
    logic [W-1:0] mock_res = '0;

    int done_cnt [N];
    int last_start_cyc = -1, last_done_cyc = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Drive inputs for the current cycle, advance one clock, then check the
    // new cycle's outputs against the reference schedule.
    task automatic step(input logic [N-1:0] st, input bit rst = 1'b0);
        logic [N-1:0] one;
        int lat;
        one = 1;
        req_start = st;
        resetn = !rst;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
            req_m[i*W +: W] = op_m[i];
        end
        if (rst) begin
            m_pend = '0; m_last = N - 1; issue_at = -1; done_at = -1;
            free_at = cyc + 1; hold_res = '0;
        end else begin
            m_pend = m_pend | st;
        end

        @(posedge clk); #1; cyc++;

        if (!mm_resetn) mock_at = -1;
        if (mm_start) begin
            mock_res = mm_a ^ mm_b;
            mock_at  = hang ? -1 : cyc + LAT;
            last_start_cyc = cyc;
        end
        mm_done   = (cyc == mock_at);
        mm_result = mm_done ? mock_res : W'($urandom);

        for (int i = 0; i < N; i++) done_cnt[i] += int'(req_done[i]);
        if (req_done != 0) last_done_cyc = cyc;

        if (cyc == done_at) hold_res = exp_res;
        chk("req_done",  req_done, (cyc == done_at) ? (one << m_grant) : '0);
        chk("req_busy",  req_busy, m_pend);
        chk("mm_start",  mm_start, cyc == issue_at);
        chk("mm_resetn", mm_resetn, (cyc >= issue_at) && (cyc < done_at));
        chk("req_result", req_result, hold_res);
        if (cyc == done_at) chk("req_err", req_err, exp_err);
        if (cyc == issue_at) chk("mm_m", mm_m, op_m[m_grant]);

        if (cyc == done_at) begin
            m_pend[m_grant] = 1'b0;
            m_last = m_grant;
        end
        if (cyc >= free_at && m_pend != 0) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (m_pend[idx]) begin
                    m_grant = idx;
                    break;
                end
            end
            lat      = hang ? TIMEOUT : LAT;
            issue_at = cyc + 1;
            done_at  = cyc + 2 + lat;
            free_at  = done_at + 1;
            exp_res  = hang ? '0 : (op_a[m_grant] ^ op_b[m_grant]);
            exp_err  = hang;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_pend != 0 || cyc < free_at) && n < 500) begin
            step('0);
            n++;
        end
        chk("drain_bound", n < 500, 1'b1);
    endtask

    task automatic run_to_done();
        int n;
        n = 0;
        while (cyc != done_at && n < 200) begin
            step('0);
            n++;
        end
        chk("wait_done_bound", n < 200, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_m[i] = W'(i + 1); done_cnt[i] = 0;
        end

        // reset
        repeat (3) step('0, 1'b1);
        chk("reset_result", req_result, '0);
        chk("reset_busy", req_busy, '0);

        // single job: latency from start to mm_start and to done
        step('0);
        op_a[0] = 16'd3; op_b[0] = 16'd5;
        begin
            int t0;
            t0 = cyc;
            step(2'b01);
            drain();
            chk("lat_start", last_start_cyc, t0 + 2);
            chk("lat_done", last_done_cyc, t0 + 2 + LAT + 1);
            chk("result_3x5", req_result, 16'd6);
        end

        // simultaneous starts, twice; then requester 1 alone twice
        op_a[0] = 16'h1111; op_b[0] = 16'h0f0f;
        op_a[1] = 16'h2222; op_b[1] = 16'h00ff;
        step(2'b11); drain();
        step(2'b11); drain();
        step(2'b10); drain();
        step(2'b10); drain();

        // re-pulse in the DONE cycle is a new job
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        op_a[1] = 16'habcd; op_b[1] = 16'h1234;
        step(2'b10);
        run_to_done();
        step(2'b10);
        drain();
        chk("repulse_dones", done_cnt[1], 2);

        // watchdog abort, then requester 1 served normally
        hang = 1'b1;
        step(2'b01);
        step(2'b10);
        run_to_done();
        chk("timeout_err", req_err, 1'b1);
        hang = 1'b0;
        drain();
        chk("after_timeout_err", req_err, 1'b0);

        // reset mid-WAIT drops everything silently
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        step(2'b11);
        begin
            int n;
            n = 0;
            while (cyc != issue_at + 3 && n < 50) begin step('0); n++; end
            chk("reach_wait_bound", n < 50, 1'b1);
        end
        step('0, 1'b1);
        repeat (15) step('0);
        chk("reset_no_done", done_cnt[0] + done_cnt[1], 0);
        op_a[0] = 16'h0055; op_b[0] = 16'h5500;
        step(2'b01); drain();
        chk("post_reset_done0", done_cnt[0], 1);

        // repeated starts while busy collapse into one job
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        step(2'b01); step('0); step(2'b01); step('0); step(2'b01);
        drain();
        chk("multi_start_one_done", done_cnt[0], 1);

        // randomized traffic
        repeat (600) begin
            logic [N-1:0] st;
            for (int i = 0; i < N; i++) begin
                st[i] = ($urandom_range(0, 3) == 0);
                if (!m_pend[i]) begin
                    op_a[i] = W'($urandom); op_b[i] = W'($urandom); op_m[i] = W'($urandom);
                end
            end
            step(st);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
